dsp_file_arbiter: RTL

DSP_FILE_ARBITER -- requirements
Module: dsp_file_arbiter

---
 rtl/dsp_file_arbiter_if.sv | 37 +++
 rtl/dsp_file_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/dsp_file_arbiter_if.sv
// dsp_file_arbiter_if: requester-side and shared file-port signals of the arbiter.
// slave is the arbiter's view; master is the requesters/file agent view.
interface dsp_file_arbiter_if;
    logic [2:0]  req;
    logic [23:0] req_file_num;
    logic [2:0]  req_write;
    logic [2:0]  req_read;
    logic [2:0]  req_reset;
    logic [95:0] req_rd_ptr_offset;
    logic [95:0] req_write_data;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic        ack_err;
    logic [31:0] rsp_read_data;
    logic [7:0]  file_num;
    logic        file_write;
    logic        file_read;
    logic        file_reset;
    logic [31:0] file_rd_ptr_offset;
    logic [31:0] file_write_data;
    logic [31:0] file_read_data;
    logic        file_active;

    modport slave (
        input  req, req_file_num, req_write, req_read, req_reset,
               req_rd_ptr_offset, req_write_data, file_read_data, file_active,
        output gnt, ack, ack_err, rsp_read_data, file_num, file_write, file_read,
               file_reset, file_rd_ptr_offset, file_write_data
    );

    modport master (
        output req, req_file_num, req_write, req_read, req_reset,
               req_rd_ptr_offset, req_write_data, file_read_data, file_active,
        input  gnt, ack, ack_err, rsp_read_data, file_num, file_write, file_read,
               file_reset, file_rd_ptr_offset, file_write_data
    );
endinterface

// File: rtl/dsp_file_arbiter.sv
// dsp_file_arbiter: 3-way round-robin arbiter of requesters onto one shared file port.
// Define DSP_FILE_ARB_TIMEOUT_EN to add the WAIT watchdog that completes with ack_err.
module dsp_file_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input logic               wb_clk,
    input logic               wb_rst,
    dsp_file_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t     state, next;
    logic [1:0] last, win, pick, c1, c2;
    logic       first, done, timed_out;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("dsp_file_arbiter: TIMEOUT must be 2..65535");
    end

    assign c1   = (last == 2'd2) ? 2'd0 : last + 2'd1;
    assign c2   = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    assign pick = bus.req[c1] ? c1 : bus.req[c2] ? c2 : last;
    // first flags the opening WAIT cycle, where file_active is not yet meaningful
    assign done = state == WAIT && !first && (!bus.file_active || timed_out);

`ifdef DSP_FILE_ARB_TIMEOUT_EN
    logic [15:0] count;

    assign timed_out = bus.file_active && count == 16'(TIMEOUT - 1);

    always_ff @(posedge wb_clk or posedge wb_rst)
        if (wb_rst) begin
            count       <= '0;
            bus.ack_err <= 1'b0;
        end else begin
            count       <= (state == WAIT) ? count + 16'd1 : '0;
            bus.ack_err <= done && timed_out;
        end
`else
    assign timed_out   = 1'b0;
    assign bus.ack_err = 1'b0;
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = |bus.req ? ISSUE : IDLE;
            ISSUE:   next = WAIT;
            WAIT:    next = done ? ACK : WAIT;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst)
        if (wb_rst) begin
            state                  <= IDLE;
            last                   <= 2'd2;
            win                    <= '0;
            first                  <= 1'b0;
            bus.gnt                <= '0;
            bus.ack                <= '0;
            bus.rsp_read_data      <= '0;
            bus.file_num           <= '0;
            bus.file_rd_ptr_offset <= '0;
            bus.file_write_data    <= '0;
            bus.file_write         <= 1'b0;
            bus.file_read          <= 1'b0;
            bus.file_reset         <= 1'b0;
        end else begin
            state          <= next;
            first          <= state == ISSUE;
            bus.ack        <= '0;
            bus.file_write <= 1'b0;
            bus.file_read  <= 1'b0;
            bus.file_reset <= 1'b0;
            if (state == IDLE && |bus.req) begin
                win                    <= pick;
                bus.gnt                <= 3'b001 << pick;
                bus.file_num           <= bus.req_file_num[pick*8 +: 8];
                bus.file_rd_ptr_offset <= bus.req_rd_ptr_offset[pick*32 +: 32];
                bus.file_write_data    <= bus.req_write_data[pick*32 +: 32];
                bus.file_reset         <= bus.req_reset[pick];
                bus.file_write         <= bus.req_write[pick] && !bus.req_reset[pick];
                bus.file_read          <= bus.req_read[pick] && !bus.req_write[pick] && !bus.req_reset[pick];
            end
            if (done) begin
                bus.ack           <= 3'b001 << win;
                bus.rsp_read_data <= timed_out ? '0 : bus.file_read_data;
            end
            if (state == ACK) begin
                last                   <= win;
                bus.gnt                <= '0;
                bus.file_num           <= '0;
                bus.file_rd_ptr_offset <= '0;
                bus.file_write_data    <= '0;
            end
        end
endmodule
